drop_controller: RTL and testbench
==================================

Name: drop_controller

Overview:
- Move-handling stage of the Connect4 datapath; sits between the player input decoder and the board memory / win checker.
- Accepts a column choice and tracks per-column fill heights with up-counters.
- Rejects illegal drops, emits the placed (row, col, player) to the downstream board stage over a valid/ready handshake, and alternates turns.
- Tracks total move count for draw detection and freezes on game over.

Parameters:
- COLS, 7, number of board columns.
- ROWS, 6, number of board rows.
- COL_W, $clog2(COLS), column index width (derived, do not override).
- ROW_W, $clog2(ROWS+1), height/row width (derived).
- CNT_W, $clog2(COLS*ROWS+1), move-count width (derived).

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- new_game  input  1  synchronous clear, same effect as reset; beats all other inputs.
- move_valid  input  1  upstream presents a move.
- move_col  input  COL_W  requested column, 0 = leftmost.
- move_ready  output  1  block can accept a move.
- reject  output  1  one-cycle pulse; move illegal (out of range or column full).
- place_valid  output  1  placement pending to downstream.
- place_ready  input  1  downstream accepts placement.
- place_row  output  ROW_W  row filled, 0 = bottom.
- place_col  output  COL_W  column filled.
- place_player  output  1  player making the move (0 = P1, 1 = P2).
- turn  output  1  player to move next.
- game_over  input  1  level from win checker; freezes block.
- board_full  output  1  all COLS*ROWS cells filled (draw).

Behaviour:
- One clock, `clock`. Asynchronous active-high reset, `reset`.
- Reset / new_game: state=IDLE, all heights=0, count=0, turn=0, latched column=0.
  - Outputs: move_ready=1 (combinational from IDLE), reject=0, place_valid=0, board_full=0.
- State machine:
  - IDLE → OVER, if game_over.
  - IDLE → CHECK, on move_valid && move_ready; latch move_col. move_ready=1 only in IDLE with game_over=0.
  - CHECK: reject=1 for this cycle if latched col ≥ COLS or height[col]==ROWS, then → IDLE. Otherwise → PLACE. No state is modified on reject.
  - PLACE: place_valid=1; place_row=height[col], place_col=col, place_player=turn. These are held stable until place_ready.
  - PLACE → on place_valid && place_ready at an edge: height[col]+=1, count+=1, turn toggles. Then → FULL if the new count == COLS*ROWS, else → IDLE.
  - FULL: board_full=1, move_ready=0; exit only by new_game or reset.
  - OVER: move_ready=0, place_valid=0; exit only by new_game or reset.
- game_over in CHECK or PLACE: the in-flight move completes normally, then → OVER instead of IDLE/FULL.
- Latency: accept edge t → CHECK during cycle t+1 → place_valid in cycle t+2. With place_ready tied high, move_ready returns in cycle t+3 (3-cycle throughput per move).
- Heights: one ROW_W counter per column, increment only; never exceeds ROWS. Out-of-range columns never index the height array.
- turn = player to move next; place_player = turn captured during PLACE.
- new_game in any state, including mid-PLACE: the pending placement is dropped with no increment.
- reset mid-operation behaves identically to new_game, but asynchronously.

Test Plan:
- Reset, then drop col 3 with place_ready=1 → place_valid in cycle t+2 with row=0, col=3, player=0; afterwards turn=1 and height[3]=1.
- Six drops into col 0, then a seventh into col 0 → rows 0..5 placed with alternating players; seventh drop gives a 1-cycle reject, no placement, turn unchanged.
- move_col=7 with COLS=7 → reject pulse in CHECK cycle; move_ready back high next cycle; no heights change.
- Hold place_ready=0 for 5 cycles in PLACE → place_valid and row/col/player stay stable, move_ready=0; release → exactly one increment.
- Fill all 42 cells without game_over → board_full=1 after the 42nd handshake, move_ready=0; new_game clears to IDLE with count=0 and turn=0.
- Assert game_over during PLACE → placement completes, then OVER with move_ready=0. Assert reset asynchronously mid-CHECK → all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/drop_controller.sv
// Connect4 move-handling stage: validates column drops against per-column fill heights,
// hands legal placements downstream over valid/ready, alternates turns and tracks draws.
module drop_controller #(
    parameter int COLS = 7,
    parameter int ROWS = 6,
    localparam int COL_W = $clog2(COLS),
    localparam int ROW_W = $clog2(ROWS + 1),
    localparam int CNT_W = $clog2(COLS * ROWS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             new_game,
    input  logic             move_valid,
    input  logic [COL_W-1:0] move_col,
    output logic             move_ready,
    output logic             reject,
    output logic             place_valid,
    input  logic             place_ready,
    output logic [ROW_W-1:0] place_row,
    output logic [COL_W-1:0] place_col,
    output logic             place_player,
    output logic             turn,
    input  logic             game_over,
    output logic             board_full
);

    localparam logic [COL_W:0]   COLS_V  = (COL_W + 1)'(COLS);
    localparam logic [ROW_W-1:0] ROWS_V  = ROW_W'(ROWS);
    localparam logic [CNT_W-1:0] TOTAL_V = CNT_W'(COLS * ROWS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        PLACE = 3'd2,
        FULL  = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [COL_W-1:0] col_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_inc;
    logic             turn_reg;
    logic             over_pending_reg;
    logic             over_pending_next;

    logic [ROW_W-1:0] col_height [COLS];
    logic [COLS-1:0]  col_hit;
    logic [ROW_W-1:0] height_sel;
    logic             in_range;
    logic             legal;
    logic             over_hold;
    logic             accept;
    logic             place_fire;

    // One-hot column decode; an out-of-range column hits nothing, so the array is never indexed with it.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            assign col_hit[gi] = (col_reg == COL_W'(gi));

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    col_height[gi] <= '0;
                end else if (new_game) begin
                    col_height[gi] <= '0;
                end else if (place_fire && col_hit[gi]) begin
                    col_height[gi] <= col_height[gi] + ROW_W'(1);
                end
            end
        end
    endgenerate

    always_comb begin
        height_sel = '0;
        for (int i = 0; i < COLS; i++) begin
            if (col_hit[i]) begin
                height_sel = col_height[i];
            end
        end
    end

    assign in_range   = ({1'b0, col_reg} < COLS_V);
    assign legal      = in_range && (height_sel != ROWS_V);
    assign over_hold  = game_over || over_pending_reg;
    assign accept     = (state_reg == IDLE) && move_valid && move_ready;
    assign place_fire = (state_reg == PLACE) && place_ready;
    assign count_inc  = count_reg + CNT_W'(1);

    assign place_row    = height_sel;
    assign place_col    = col_reg;
    assign place_player = turn_reg;
    assign turn         = turn_reg;

    // A game_over seen while a move is in flight is remembered until that move retires.
    assign over_pending_next = ((state_reg == CHECK) || (state_reg == PLACE)) ?
                               (over_pending_reg || game_over) : 1'b0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else if (new_game) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        move_ready  = 1'b0;
        reject      = 1'b0;
        place_valid = 1'b0;
        board_full  = 1'b0;
        case (state_reg)
            IDLE: begin
                move_ready = !game_over;
                if (game_over) begin
                    state_next = OVER;
                end else if (move_valid) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (!legal) begin
                    reject     = 1'b1;
                    state_next = over_hold ? OVER : IDLE;
                end else begin
                    state_next = PLACE;
                end
            end
            PLACE: begin
                place_valid = 1'b1;
                if (place_ready) begin
                    if (over_hold) begin
                        state_next = OVER;
                    end else if (count_inc == TOTAL_V) begin
                        state_next = FULL;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            FULL: begin
                board_full = 1'b1;
            end
            OVER: begin
                state_next = OVER;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_reg          <= '0;
            count_reg        <= '0;
            turn_reg         <= 1'b0;
            over_pending_reg <= 1'b0;
        end else if (new_game) begin
            col_reg          <= '0;
            count_reg        <= '0;
            turn_reg         <= 1'b0;
            over_pending_reg <= 1'b0;
        end else begin
            over_pending_reg <= over_pending_next;
            if (accept) begin
                col_reg <= move_col;
            end
            if (place_fire) begin
                count_reg <= count_inc;
                turn_reg  <= !turn_reg;
            end
        end
    end

endmodule

// File: tb/tb_drop_controller.sv
// Directed bench for drop_controller: each scenario task drives moves and checks
// the handshake, reject, placement and turn outputs against hand-computed values.
module tb_drop_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       new_game;
    logic       move_valid;
    logic [2:0] move_col;
    logic       move_ready;
    logic       reject;
    logic       place_valid;
    logic       place_ready;
    logic [2:0] place_row;
    logic [2:0] place_col;
    logic       place_player;
    logic       turn;
    logic       game_over;
    logic       board_full;

    int checks = 0;
    int passed = 0;

    drop_controller #(.COLS(7), .ROWS(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .new_game     (new_game),
        .move_valid   (move_valid),
        .move_col     (move_col),
        .move_ready   (move_ready),
        .reject       (reject),
        .place_valid  (place_valid),
        .place_ready  (place_ready),
        .place_row    (place_row),
        .place_col    (place_col),
        .place_player (place_player),
        .turn         (turn),
        .game_over    (game_over),
        .board_full   (board_full)
    );

    always #5 clock = ~clock;

    // Drives one move from IDLE with place_ready already high and reports what was seen;
    // returns #1 after the edge that leaves CHECK (reject) or PLACE (handshake).
    task automatic do_move(input logic [2:0] col, output logic rej, output logic pv,
                           output logic [2:0] row, output logic [2:0] pcol, output logic pl);
        move_valid = 1'b1;
        move_col   = col;
        @(posedge clock); #1;
        move_valid = 1'b0;
        rej = reject;
        @(posedge clock); #1;
        pv   = place_valid;
        row  = place_row;
        pcol = place_col;
        pl   = place_player;
        if (pv) begin
            @(posedge clock); #1;
        end
        $display("move col=%0d reject=%0b place_valid=%0b row=%0d col=%0d player=%0b turn=%0b",
                 col, rej, pv, row, pcol, pl, turn);
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(posedge clock); #1;
        new_game = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_col = '0;
        place_ready = 1'b1; game_over = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        checks++; if (move_ready !== 1'b1) $display("FAIL reset_move_ready got=%0b exp=1", move_ready); else passed++;
        checks++; if (reject !== 1'b0) $display("FAIL reset_reject got=%0b exp=0", reject); else passed++;
        checks++; if (place_valid !== 1'b0) $display("FAIL reset_place_valid got=%0b exp=0", place_valid); else passed++;
        checks++; if (board_full !== 1'b0) $display("FAIL reset_board_full got=%0b exp=0", board_full); else passed++;
        checks++; if (turn !== 1'b0) $display("FAIL reset_turn got=%0b exp=0", turn); else passed++;
        $display("reset: move_ready=%0b reject=%0b place_valid=%0b board_full=%0b turn=%0b",
                 move_ready, reject, place_valid, board_full, turn);
    endtask

    task automatic test_single_drop();
        logic r, pv, pl;
        logic [2:0] row, pc;
        move_valid = 1'b1; move_col = 3'd3;
        @(posedge clock); #1;
        move_valid = 1'b0;
        checks++; if (move_ready !== 1'b0) $display("FAIL single_check_ready got=%0b exp=0", move_ready); else passed++;
        checks++; if (place_valid !== 1'b0) $display("FAIL single_check_pv got=%0b exp=0", place_valid); else passed++;
        checks++; if (reject !== 1'b0) $display("FAIL single_check_reject got=%0b exp=0", reject); else passed++;
        @(posedge clock); #1;
        checks++; if (place_valid !== 1'b1) $display("FAIL single_place_valid got=%0b exp=1", place_valid); else passed++;
        checks++; if (place_row !== 3'd0) $display("FAIL single_row got=%0d exp=0", place_row); else passed++;
        checks++; if (place_col !== 3'd3) $display("FAIL single_col got=%0d exp=3", place_col); else passed++;
        checks++; if (place_player !== 1'b0) $display("FAIL single_player got=%0b exp=0", place_player); else passed++;
        @(posedge clock); #1;
        checks++; if (turn !== 1'b1) $display("FAIL single_turn got=%0b exp=1", turn); else passed++;
        checks++; if (move_ready !== 1'b1) $display("FAIL single_ready_back got=%0b exp=1", move_ready); else passed++;
        $display("single drop col=3 done: turn=%0b move_ready=%0b", turn, move_ready);
        do_move(3'd3, r, pv, row, pc, pl);
        checks++; if (row !== 3'd1) $display("FAIL single_second_row got=%0d exp=1", row); else passed++;
        checks++; if (pl !== 1'b1) $display("FAIL single_second_player got=%0b exp=1", pl); else passed++;
    endtask

    task automatic test_column_full();
        logic r, pv, pl;
        logic [2:0] row, pc;
        pulse_new_game();
        for (int i = 0; i < 6; i++) begin
            do_move(3'd0, r, pv, row, pc, pl);
            checks++; if (r !== 1'b0 || pv !== 1'b1) $display("FAIL colfull_accept%0d got=rej%0b/pv%0b exp=rej0/pv1", i, r, pv); else passed++;
            checks++; if (row !== 3'(i)) $display("FAIL colfull_row%0d got=%0d exp=%0d", i, row, i); else passed++;
            checks++; if (pl !== 1'(i % 2)) $display("FAIL colfull_player%0d got=%0b exp=%0d", i, pl, i % 2); else passed++;
        end
        do_move(3'd0, r, pv, row, pc, pl);
        checks++; if (r !== 1'b1) $display("FAIL colfull_reject got=%0b exp=1", r); else passed++;
        checks++; if (pv !== 1'b0) $display("FAIL colfull_no_place got=%0b exp=0", pv); else passed++;
        checks++; if (reject !== 1'b0) $display("FAIL colfull_reject_one_cycle got=%0b exp=0", reject); else passed++;
        checks++; if (turn !== 1'b0) $display("FAIL colfull_turn got=%0b exp=0", turn); else passed++;
    endtask

    task automatic test_out_of_range();
        logic r, pv, pl;
        logic [2:0] row, pc;
        do_move(3'd7, r, pv, row, pc, pl);
        checks++; if (r !== 1'b1) $display("FAIL oor_reject got=%0b exp=1", r); else passed++;
        checks++; if (pv !== 1'b0) $display("FAIL oor_no_place got=%0b exp=0", pv); else passed++;
        checks++; if (move_ready !== 1'b1) $display("FAIL oor_ready_back got=%0b exp=1", move_ready); else passed++;
        do_move(3'd0, r, pv, row, pc, pl);
        checks++; if (r !== 1'b1) $display("FAIL oor_col0_still_full got=%0b exp=1", r); else passed++;
        do_move(3'd6, r, pv, row, pc, pl);
        checks++; if (pv !== 1'b1 || row !== 3'd0) $display("FAIL oor_col6_row got=pv%0b/row%0d exp=pv1/row0", pv, row); else passed++;
        checks++; if (pc !== 3'd6 || pl !== 1'b0) $display("FAIL oor_col6_tag got=col%0d/pl%0b exp=col6/pl0", pc, pl); else passed++;
    endtask

    task automatic test_backpressure();
        logic r, pv, pl;
        logic [2:0] row, pc;
        pulse_new_game();
        place_ready = 1'b0;
        move_valid = 1'b1; move_col = 3'd2;
        @(posedge clock); #1;
        move_valid = 1'b0;
        @(posedge clock); #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (place_valid !== 1'b1) $display("FAIL bp_pv%0d got=%0b exp=1", k, place_valid); else passed++;
            checks++; if (place_row !== 3'd0 || place_col !== 3'd2 || place_player !== 1'b0)
                $display("FAIL bp_payload%0d got=%0d/%0d/%0b exp=0/2/0", k, place_row, place_col, place_player); else passed++;
            checks++; if (move_ready !== 1'b0) $display("FAIL bp_ready%0d got=%0b exp=0", k, move_ready); else passed++;
            $display("stall cycle %0d: place_valid=%0b row=%0d col=%0d", k, place_valid, place_row, place_col);
            @(posedge clock); #1;
        end
        place_ready = 1'b1;
        @(posedge clock); #1;
        checks++; if (place_valid !== 1'b0 || move_ready !== 1'b1) $display("FAIL bp_release got=pv%0b/rdy%0b exp=pv0/rdy1", place_valid, move_ready); else passed++;
        checks++; if (turn !== 1'b1) $display("FAIL bp_turn got=%0b exp=1", turn); else passed++;
        do_move(3'd2, r, pv, row, pc, pl);
        checks++; if (row !== 3'd1) $display("FAIL bp_single_increment got=%0d exp=1", row); else passed++;
    endtask

    task automatic test_board_full();
        logic r, pv, pl;
        logic [2:0] row, pc;
        int bad;
        pulse_new_game();
        bad = 0;
        for (int c = 0; c < 7; c++) begin
            for (int h = 0; h < 6; h++) begin
                do_move(3'(c), r, pv, row, pc, pl);
                if (r !== 1'b0 || pv !== 1'b1 || row !== 3'(h) || pc !== 3'(c) || pl !== 1'((c * 6 + h) % 2)) bad++;
                if (c == 6 && h == 4) begin
                    checks++; if (board_full !== 1'b0) $display("FAIL full_early got=%0b exp=0", board_full); else passed++;
                end
            end
        end
        checks++; if (bad !== 0) $display("FAIL full_fill_errors got=%0d exp=0", bad); else passed++;
        checks++; if (board_full !== 1'b1) $display("FAIL full_flag got=%0b exp=1", board_full); else passed++;
        checks++; if (move_ready !== 1'b0) $display("FAIL full_ready got=%0b exp=0", move_ready); else passed++;
        move_valid = 1'b1; move_col = 3'd1;
        repeat (2) @(posedge clock);
        #1 move_valid = 1'b0;
        checks++; if (board_full !== 1'b1 || place_valid !== 1'b0) $display("FAIL full_sticky got=bf%0b/pv%0b exp=bf1/pv0", board_full, place_valid); else passed++;
        pulse_new_game();
        checks++; if (board_full !== 1'b0 || move_ready !== 1'b1) $display("FAIL full_clear got=bf%0b/rdy%0b exp=bf0/rdy1", board_full, move_ready); else passed++;
        checks++; if (turn !== 1'b0) $display("FAIL full_clear_turn got=%0b exp=0", turn); else passed++;
        do_move(3'd5, r, pv, row, pc, pl);
        checks++; if (pv !== 1'b1 || row !== 3'd0 || pl !== 1'b0) $display("FAIL full_fresh_drop got=pv%0b/row%0d/pl%0b exp=pv1/row0/pl0", pv, row, pl); else passed++;
    endtask

    task automatic test_game_over();
        pulse_new_game();
        place_ready = 1'b0;
        move_valid = 1'b1; move_col = 3'd4;
        @(posedge clock); #1;
        move_valid = 1'b0;
        @(posedge clock); #1;
        game_over = 1'b1;
        checks++; if (place_valid !== 1'b1 || move_ready !== 1'b0) $display("FAIL go_in_place got=pv%0b/rdy%0b exp=pv1/rdy0", place_valid, move_ready); else passed++;
        place_ready = 1'b1;
        @(posedge clock); #1;
        checks++; if (place_valid !== 1'b0 || move_ready !== 1'b0) $display("FAIL go_over got=pv%0b/rdy%0b exp=pv0/rdy0", place_valid, move_ready); else passed++;
        checks++; if (turn !== 1'b1) $display("FAIL go_move_completed got=%0b exp=1", turn); else passed++;
        game_over = 1'b0;
        @(posedge clock); #1;
        checks++; if (move_ready !== 1'b0) $display("FAIL go_frozen got=%0b exp=0", move_ready); else passed++;
        $display("game over: move_ready=%0b turn=%0b", move_ready, turn);
        pulse_new_game();
        checks++; if (move_ready !== 1'b1 || turn !== 1'b0) $display("FAIL go_new_game got=rdy%0b/turn%0b exp=rdy1/turn0", move_ready, turn); else passed++;
    endtask

    task automatic test_async_reset();
        logic r, pv, pl;
        logic [2:0] row, pc;
        do_move(3'd1, r, pv, row, pc, pl);
        move_valid = 1'b1; move_col = 3'd7;
        @(posedge clock); #1;
        move_valid = 1'b0;
        checks++; if (reject !== 1'b1 || turn !== 1'b1) $display("FAIL ar_pre got=rej%0b/turn%0b exp=rej1/turn1", reject, turn); else passed++;
        #1 reset = 1'b1;
        #1;
        checks++; if (reject !== 1'b0) $display("FAIL ar_reject got=%0b exp=0", reject); else passed++;
        checks++; if (turn !== 1'b0) $display("FAIL ar_turn got=%0b exp=0", turn); else passed++;
        checks++; if (move_ready !== 1'b1 || place_valid !== 1'b0 || board_full !== 1'b0)
            $display("FAIL ar_outputs got=rdy%0b/pv%0b/bf%0b exp=rdy1/pv0/bf0", move_ready, place_valid, board_full); else passed++;
        $display("async reset mid-check: reject=%0b turn=%0b move_ready=%0b", reject, turn, move_ready);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        do_move(3'd1, r, pv, row, pc, pl);
        checks++; if (row !== 3'd0 || pl !== 1'b0) $display("FAIL ar_heights_cleared got=row%0d/pl%0b exp=row0/pl0", row, pl); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_drop();
        test_column_full();
        test_out_of_range();
        test_backpressure();
        test_board_full();
        test_game_over();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
